gmii_rx_frame_align: RTL and testbench

Receive-side GMII front end: takes raw PHY receive bytes (`gmii_rxd`/`gmii_rx_dv`/`gmii_rx_er`) and delivers clean frame bytes to `gmii_to_134b_pkt`.

- Strips preamble and SFD.
- Removes the 4-byte FCS through a delay line.
- Aborts errored frames.
- Produces a contiguous `gmii_data_valid` burst per frame, which the downstream packer uses as its frame boundary.
- Sits between the PHY/RGMII adapter and the 134b packer in the RX path.

---
 rtl/gmii_pkg.sv | 18 +
 rtl/crc32_d8.sv | 24 ++
 rtl/gmii_rx_frame_align.sv | 128 ++++++++++++
 tb/tb_gmii_rx_frame_align.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_pkg.sv
// Shared GMII constants: framing bytes, CRC-32 parameters and RX state encoding.
package gmii_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        IDLE_S     = 2'd0,
        PREAMBLE_S = 2'd1,
        DATA_S     = 2'd2,
        DROP_S     = 2'd3
    } rx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 update for one byte (LSB first).
module crc32_d8
    import gmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC32_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_rx_frame_align.sv
// GMII RX front end: strips preamble/SFD, drops the FCS via a 4-byte delay line, aborts errored
// frames. Optional FCS check enabled by defining GMII_RX_FCS_CHECK_EN.
module gmii_rx_frame_align
    import gmii_pkg::*;
#(
    parameter int unsigned PRE_MIN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  gmii_data,
    output logic        gmii_data_valid,
    output logic        fcs_err,
    output logic [31:0] cnt_frame,
    output logic [31:0] cnt_err
);

    localparam logic [3:0] PRE_MIN_W = 4'(PRE_MIN);

    rx_state_e  state;
    logic       dv_d;
    logic [3:0] cnt_pre;
    logic [7:0] sr [4];
    logic [2:0] fill;
    logic       emitted;

`ifdef GMII_RX_FCS_CHECK_EN
    logic [31:0] crc;
    logic [31:0] crc_next;

    crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (gmii_rxd),
        .crc_out (crc_next)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE_S;
            dv_d            <= 1'b1;  // ignore a frame already in flight at reset release
            cnt_pre         <= 4'd0;
            for (int i = 0; i < 4; i++) sr[i] <= 8'h00;
            fill            <= 3'd0;
            emitted         <= 1'b0;
            gmii_data       <= 8'h00;
            gmii_data_valid <= 1'b0;
            fcs_err         <= 1'b0;
            cnt_frame       <= 32'd0;
            cnt_err         <= 32'd0;
`ifdef GMII_RX_FCS_CHECK_EN
            crc             <= CRC32_INIT;
`endif
        end else begin
            dv_d            <= gmii_rx_dv;
            gmii_data_valid <= 1'b0;
            fcs_err         <= 1'b0;
            unique case (state)
                IDLE_S: begin
                    if (gmii_rx_dv && !dv_d) begin
                        if (gmii_rxd == PREAMBLE_BYTE) begin
                            cnt_pre <= 4'd1;
                            state   <= PREAMBLE_S;
                        end else begin
                            cnt_err <= cnt_err + 32'd1;
                            state   <= DROP_S;
                        end
                    end
                end
                PREAMBLE_S: begin
                    if (!gmii_rx_dv) begin
                        state <= IDLE_S;
                    end else if (gmii_rxd == PREAMBLE_BYTE) begin
                        if (cnt_pre != 4'd15) cnt_pre <= cnt_pre + 4'd1;
                    end else if (gmii_rxd == SFD_BYTE && cnt_pre >= PRE_MIN_W) begin
                        for (int i = 0; i < 4; i++) sr[i] <= 8'h00;
                        fill    <= 3'd0;
                        emitted <= 1'b0;
`ifdef GMII_RX_FCS_CHECK_EN
                        crc     <= CRC32_INIT;
`endif
                        state   <= DATA_S;
                    end else begin
                        cnt_err <= cnt_err + 32'd1;
                        state   <= DROP_S;
                    end
                end
                DATA_S: begin
                    if (gmii_rx_er) begin
                        cnt_err <= cnt_err + 32'd1;
                        state   <= DROP_S;
                    end else if (!gmii_rx_dv) begin
                        // Delay line now holds the FCS; it is simply abandoned.
                        if (emitted) cnt_frame <= cnt_frame + 32'd1;
                        if (fill != 3'd4) cnt_err <= cnt_err + 32'd1;
`ifdef GMII_RX_FCS_CHECK_EN
                        else if (crc != CRC32_RESIDUE) begin
                            fcs_err <= 1'b1;
                            cnt_err <= cnt_err + 32'd1;
                        end
`endif
                        state <= IDLE_S;
                    end else begin
                        sr[0] <= gmii_rxd;
                        for (int i = 1; i < 4; i++) sr[i] <= sr[i-1];
`ifdef GMII_RX_FCS_CHECK_EN
                        crc   <= crc_next;
`endif
                        if (fill == 3'd4) begin
                            gmii_data       <= sr[3];
                            gmii_data_valid <= 1'b1;
                            emitted         <= 1'b1;
                        end else begin
                            fill <= fill + 3'd1;
                        end
                    end
                end
                DROP_S: begin
                    if (!gmii_rx_dv) state <= IDLE_S;
                end
                default: state <= IDLE_S;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_rx_frame_align.sv
// Directed, table-driven bench for gmii_rx_frame_align (PRE_MIN = 2).
module tb_gmii_rx_frame_align;

`ifdef GMII_RX_FCS_CHECK_EN
    localparam bit FcsOn = 1'b1;
`else
    localparam bit FcsOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  gmii_data;
    logic        gmii_data_valid;
    logic        fcs_err;
    logic [31:0] cnt_frame;
    logic [31:0] cnt_err;

    always #5 clk = ~clk;

    gmii_rx_frame_align #(.PRE_MIN(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .gmii_rxd        (gmii_rxd),
        .gmii_rx_dv      (gmii_rx_dv),
        .gmii_rx_er      (gmii_rx_er),
        .gmii_data       (gmii_data),
        .gmii_data_valid (gmii_data_valid),
        .fcs_err         (fcs_err),
        .cnt_frame       (cnt_frame),
        .cnt_err         (cnt_err)
    );

    typedef struct {
        int         pre;     // 0 => dv rises on 'first' followed by 40 filler bytes
        logic [7:0] sfd;
        logic [7:0] first;
        int         pay;     // payload bytes 0,1,2,...
        int         fcs;     // 0 none, 1 good, 2 last byte ^ 0x01
        int         er_at;   // post-SFD index carrying rx_er, -1 none
        int         nbytes;  // expected emitted bytes
        int         frame;   // expected cnt_frame increment
        int         err;     // expected cnt_err increment, excluding FCS errors
    } vec_t;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;
    int exp_errs = 0;

    int         cyc = 0;
    logic       prev_v = 1'b0;
    logic [7:0] got [$];
    int         runs, fcs_pulses, fcs_aligned, first_cyc, exp_first, snap;
    bit         rst_viol;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (gmii_data_valid) begin
            if (!prev_v) begin
                runs++;
                if (got.size() == 0) first_cyc = cyc;
            end
            got.push_back(gmii_data);
        end
        if (fcs_err) begin
            fcs_pulses++;
            if (prev_v && !gmii_data_valid) fcs_aligned++;
        end
        if (!rst_n && (gmii_data_valid || gmii_data != 8'h00 || fcs_err ||
                       cnt_frame != 32'd0 || cnt_err != 32'd0)) rst_viol = 1'b1;
        prev_v = gmii_data_valid;
    end

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic clear_mon();
        got.delete();
        runs = 0;
        fcs_pulses = 0;
        fcs_aligned = 0;
        first_cyc = -1;
        exp_first = -2;
        rst_viol = 1'b0;
    endtask

    task automatic drive(input logic [7:0] b, input logic dv, input logic er);
        @(negedge clk);
        gmii_rxd   = b;
        gmii_rx_dv = dv;
        gmii_rx_er = er;
    endtask

    task automatic send(input int pre, input logic [7:0] sfd, input logic [7:0] first,
                        input int pay, input int fcs, input int er_at, input int rst_at);
        logic [7:0]  q [$];
        logic [31:0] c;
        int          post_start;
        int          p;
        if (pre == 0) begin
            q.push_back(first);
            for (int i = 0; i < 40; i++) q.push_back(8'(i));
            post_start = -1;
        end else begin
            for (int i = 0; i < pre; i++) q.push_back(8'h55);
            q.push_back(sfd);
            post_start = q.size();
            c = 32'hFFFFFFFF;
            for (int i = 0; i < pay; i++) begin
                q.push_back(8'(i));
                c = crc_byte(c, 8'(i));
            end
            if (fcs > 0) begin
                c = ~c;
                q.push_back(c[7:0]);
                q.push_back(c[15:8]);
                q.push_back(c[23:16]);
                q.push_back(c[31:24]);
                if (fcs == 2) q[q.size()-1] = q[q.size()-1] ^ 8'h01;
            end
        end
        for (int k = 0; k < q.size(); k++) begin
            p = (post_start < 0) ? -100 : k - post_start;
            drive(q[k], 1'b1, (er_at >= 0 && p == er_at));
            if (p == 4) exp_first = cyc + 1;
            if (rst_at >= 0 && p == rst_at) begin
                rst_n = 1'b0;
                snap  = got.size();
            end
            if (rst_at >= 0 && p == rst_at + 2) rst_n = 1'b1;
        end
        repeat (10) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int bad;
        bit fcs_hit;
        clear_mon();
        send(v.pre, v.sfd, v.first, v.pay, v.fcs, v.er_at, -1);
        fcs_hit = FcsOn && (v.fcs == 2);
        exp_frames += v.frame;
        exp_errs   += v.err + (fcs_hit ? 1 : 0);
        check({tag, ".bytes"}, got.size(), v.nbytes);
        bad = 0;
        for (int i = 0; i < got.size(); i++) if (got[i] !== 8'(i)) bad++;
        check({tag, ".data_mismatches"}, bad, 0);
        check({tag, ".runs"}, runs, (v.nbytes > 0) ? 1 : 0);
        if (v.nbytes > 0) check({tag, ".latency_cycle"}, first_cyc, exp_first);
        check({tag, ".fcs_pulses"}, fcs_pulses, fcs_hit ? 1 : 0);
        check({tag, ".fcs_after_fall"}, fcs_aligned, fcs_hit ? 1 : 0);
        check({tag, ".cnt_frame"}, cnt_frame, exp_frames);
        check({tag, ".cnt_err"}, cnt_err, exp_errs);
    endtask

    vec_t vecs [12];
    vec_t clean;

    initial begin
        vecs[0]  = '{7,  8'hD5, 8'h55, 64, 1, -1, 64, 1, 0};  // clean
        vecs[1]  = '{7,  8'hD5, 8'h55, 64, 2, -1, 64, 1, 0};  // corrupted FCS
        vecs[2]  = '{7,  8'hD5, 8'h55, 3,  0, -1, 0,  0, 1};  // runt
        vecs[3]  = '{0,  8'hD5, 8'hAA, 0,  0, -1, 0,  0, 1};  // bad start
        vecs[4]  = '{7,  8'hD5, 8'h55, 64, 1, -1, 64, 1, 0};  // recovers after drop
        vecs[5]  = '{7,  8'hD5, 8'h55, 64, 1, 20, 16, 0, 1};  // rx_er on byte 20
        vecs[6]  = '{1,  8'hD5, 8'h55, 10, 1, -1, 0,  0, 1};  // preamble below PRE_MIN
        vecs[7]  = '{2,  8'hD5, 8'h55, 10, 1, -1, 10, 1, 0};  // preamble == PRE_MIN
        vecs[8]  = '{20, 8'hD5, 8'h55, 8,  1, -1, 8,  1, 0};  // preamble counter saturates
        vecs[9]  = '{3,  8'h12, 8'h55, 10, 1, -1, 0,  0, 1};  // bad SFD byte
        vecs[10] = '{7,  8'hD5, 8'h55, 1,  1, -1, 1,  1, 0};  // L = 5, minimum emitting
        vecs[11] = '{0,  8'hD5, 8'hD5, 0,  0, -1, 0,  0, 1};  // dv rises on SFD
        clean    = vecs[0];

        rst_n      = 1'b0;
        gmii_rxd   = 8'h00;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        clear_mon();
        repeat (3) drive(8'h00, 1'b0, 1'b0);
        check("reset.data", gmii_data, 0);
        check("reset.valid", gmii_data_valid, 0);
        check("reset.fcs_err", fcs_err, 0);
        check("reset.cnt_frame", cnt_frame, 0);
        check("reset.cnt_err", cnt_err, 0);
        rst_n = 1'b1;
        repeat (4) drive(8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Reset in the data phase with dv held high: nothing more may come out of that frame.
        clear_mon();
        send(7, 8'hD5, 8'h55, 64, 1, -1, 30);
        exp_frames = 0;
        exp_errs   = 0;
        check("rstmid.outputs_zero_in_reset", rst_viol, 0);
        check("rstmid.bytes_before_reset", snap, 26);
        check("rstmid.bytes_after_reset", got.size(), snap);
        check("rstmid.cnt_frame", cnt_frame, 0);
        check("rstmid.cnt_err", cnt_err, 0);
        run_vec("rstmid.next", clean);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
